// File: rtl/one_hot_pkg.sv
// one_hot_pkg: shared types and the golden signed-to-one-hot mapping for the
// 16-position one-hot code. Bit index = 7 - value, so -8 -> bit 15, 7 -> bit 0.
package one_hot_pkg;

    localparam int ONE_HOT_W = 16;

    typedef logic signed [3:0]      sval_t;
    typedef logic [ONE_HOT_W-1:0]   onehot_t;

    // Output buffer occupancy; the encoding doubles as the entry count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    // Index is formed at 5-bit signed width so 7 - (-8) = 15 cannot wrap.
    function automatic onehot_t to_one_hot(input sval_t v);
        logic signed [4:0] idx;
        idx = 5'sd7 - $signed({v[3], v});
        return onehot_t'(1) << idx[3:0];
    endfunction

endpackage

// File: rtl/one_hot_fifo2.sv
// one_hot_fifo2: 2-entry in-order buffer of one-hot words.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous flush, overrides push and pop
//   push, din   write din (ignored while full)
//   pop         drop the head entry (ignored while empty)
//   head        oldest entry (slot0)
//   full, empty occupancy flags
module one_hot_fifo2
    import one_hot_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    clr,
    input  logic    push,
    input  logic    pop,
    input  onehot_t din,
    output onehot_t head,
    output logic    full,
    output logic    empty
);

    occ_t    state, state_nxt;
    onehot_t slot0, slot1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= OCC_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            OCC_EMPTY: if (push) state_nxt = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop)      state_nxt = OCC_FULL;
                else if (pop && !push) state_nxt = OCC_EMPTY;
            end
            OCC_FULL:  if (pop) state_nxt = OCC_ONE;
            default:   state_nxt = OCC_EMPTY;
        endcase
        if (clr) state_nxt = OCC_EMPTY;
    end

    // slot0 is always the head; a pop from FULL shifts slot1 forward.
    // A push into FULL is dropped even with a same-cycle pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
        end else if (!clr) begin
            case (state)
                OCC_EMPTY: if (push) slot0 <= din;
                OCC_ONE: begin
                    if (push && pop) slot0 <= din;
                    else if (push)   slot1 <= din;
                end
                OCC_FULL:  if (pop) slot0 <= slot1;
                default: ;
            endcase
        end
    end

    assign head  = slot0;
    assign full  = (state == OCC_FULL);
    assign empty = (state == OCC_EMPTY);

endmodule

// File: rtl/one_hot_decoder.sv
// one_hot_decoder: streaming signed 4-bit -> 16-bit one-hot decoder with a
// 2-entry registered output buffer and valid/ready on both sides.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   clr                  synchronous flush of buffer and counter
//   in_valid/in_ready    input handshake, in_y signed value -8..7
//   out_valid/out_ready  output handshake, out_w one-hot word (0 when idle)
//   dec_count            saturating accepted-sample count
// Build option: define ONE_HOT_DEC_CNT_EN to enable dec_count; otherwise the
// counter is absent and dec_count reads 0.
module one_hot_decoder
    import one_hot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_w,
    output logic [7:0]  dec_count
);

    logic    rdy_en;
    logic    push, pop;
    logic    full, empty;
    onehot_t head;

    // Holds in_ready low through reset and until the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

    // in_ready looks only at registered state, never at out_ready.
    assign in_ready  = rdy_en && !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_w     = out_valid ? head : '0;

    one_hot_fifo2 u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   (to_one_hot(sval_t'(in_y))),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

`ifdef ONE_HOT_DEC_CNT_EN
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       cnt <= '0;
        else if (clr)                     cnt <= '0;
        else if (push && cnt != 8'hFF)    cnt <= cnt + 8'd1;
    end

    assign dec_count = cnt;
`else
    assign dec_count = 8'd0;
`endif

endmodule
